// File: rtl/cond_exec_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cond_exec_pipe_ctrl
// Purpose  : Decode-to-execute sequencer for the filter GPU core. Registers
//            decode controls into E, owns the NZCV flag register, evaluates
//            the 4-bit condition field in E, gates writes for failed
//            conditions, stalls decode on load-use hazards and flushes the
//            wrong-path decode slot(s) after a taken branch.
// Revision : 1.0  initial release
// ============================================================================
module cond_exec_pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,   // FlushD high-time after a taken branch (1..7)
  parameter int RA_W         = 4    // register-address width
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Valid_D,
  input  logic [3:0]      Cond_D,
  input  logic            RegW_D,
  input  logic            MemW_D,
  input  logic            MemToReg_D,
  input  logic            Branch_D,
  input  logic            FlagW_D,
  input  logic [RA_W-1:0] RA1_D,
  input  logic [RA_W-1:0] RA2_D,
  input  logic [RA_W-1:0] WA3_D,
  input  logic [3:0]      ALUFlags_E,
  output logic            RegW_E,
  output logic            MemW_E,
  output logic            MemToReg_E,
  output logic            PCSrc_E,
  output logic            StallD,
  output logic            FlushD,
  output logic [3:0]      Flags
);

  // Counter reload value: the branch cycle itself is the first flush cycle.
  localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  // E-stage pipeline register
  logic            r_valid_e;
  logic [3:0]      r_cond_e;
  logic            r_regw_e;
  logic            r_memw_e;
  logic            r_memtoreg_e;
  logic            r_branch_e;
  logic            r_flagw_e;
  logic [RA_W-1:0] r_wa3_e;

  // Architectural state
  logic [3:0]      r_flags;
  logic [2:0]      r_flush_cnt;

  // Combinational control
  logic            w_cond_raw;
  logic            w_condex;
  logic            w_pcsrc;
  logic            w_flush;
  logic            w_hazard;
  logic            w_stall;
  logic            w_load_e;
  logic            w_n;
  logic            w_z;
  logic            w_c;
  logic            w_v;

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // Condition-field decode against the current architectural flags
  always_comb begin
    w_cond_raw = 1'b0;
    case (r_cond_e)
      4'h0:    w_cond_raw = w_z;
      4'h1:    w_cond_raw = ~w_z;
      4'h2:    w_cond_raw = w_c;
      4'h3:    w_cond_raw = ~w_c;
      4'h4:    w_cond_raw = w_n;
      4'h5:    w_cond_raw = ~w_n;
      4'h6:    w_cond_raw = w_v;
      4'h7:    w_cond_raw = ~w_v;
      4'h8:    w_cond_raw = w_c & ~w_z;
      4'h9:    w_cond_raw = ~w_c | w_z;
      4'hA:    w_cond_raw = (w_n == w_v);
      4'hB:    w_cond_raw = (w_n != w_v);
      4'hC:    w_cond_raw = ~w_z & (w_n == w_v);
      4'hD:    w_cond_raw = w_z | (w_n != w_v);
      4'hE:    w_cond_raw = 1'b1;
      default: w_cond_raw = 1'b0;
    endcase
  end

  // A bubble never passes its condition, so it can never write or redirect.
  assign w_condex = r_valid_e & w_cond_raw;
  assign w_pcsrc  = r_branch_e & w_condex;

  // Flush covers the redirect cycle plus whatever the counter still holds.
  assign w_flush  = w_pcsrc | (r_flush_cnt != 3'd0);

  // Load-use: a load that will actually write a register read by D this cycle.
  assign w_hazard = r_valid_e & r_memtoreg_e & r_regw_e & w_condex & Valid_D
                  & ((r_wa3_e == RA1_D) | (r_wa3_e == RA2_D));

  // Flush wins over stall: the stalled instruction is wrong-path anyway.
  assign w_stall  = w_hazard & ~w_flush;

  assign w_load_e = Valid_D & ~w_stall & ~w_flush;

  assign RegW_E     = r_regw_e & w_condex;
  assign MemW_E     = r_memw_e & w_condex;
  assign MemToReg_E = r_memtoreg_e;
  assign PCSrc_E    = w_pcsrc;
  assign StallD     = w_stall;
  assign FlushD     = w_flush;
  assign Flags      = r_flags;

  // E-stage register, flag register and flush counter
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_valid_e    <= 1'b0;
      r_cond_e     <= 4'h0;
      r_regw_e     <= 1'b0;
      r_memw_e     <= 1'b0;
      r_memtoreg_e <= 1'b0;
      r_branch_e   <= 1'b0;
      r_flagw_e    <= 1'b0;
      r_wa3_e      <= '0;
      r_flags      <= 4'h0;
      r_flush_cnt  <= 3'd0;
    end else begin
      if (w_load_e) begin
        r_valid_e    <= 1'b1;
        r_cond_e     <= Cond_D;
        r_regw_e     <= RegW_D;
        r_memw_e     <= MemW_D;
        r_memtoreg_e <= MemToReg_D;
        r_branch_e   <= Branch_D;
        r_flagw_e    <= FlagW_D;
        r_wa3_e      <= WA3_D;
      end else begin
        r_valid_e    <= 1'b0;
        r_cond_e     <= 4'h0;
        r_regw_e     <= 1'b0;
        r_memw_e     <= 1'b0;
        r_memtoreg_e <= 1'b0;
        r_branch_e   <= 1'b0;
        r_flagw_e    <= 1'b0;
        r_wa3_e      <= '0;
      end

      if (r_flagw_e & w_condex) begin
        r_flags <= ALUFlags_E;
      end

      if (w_pcsrc) begin
        r_flush_cnt <= c_FLUSH_LOAD;
      end else if (r_flush_cnt != 3'd0) begin
        r_flush_cnt <= r_flush_cnt - 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cond_exec_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_exec_pipe_ctrl
// Purpose  : Scoreboard bench for cond_exec_pipe_ctrl. Two instances
//            (FLUSH_CYCLES = 2 and 3) share one stimulus stream; a
//            behavioural model predicts each cycle's outputs and a monitor
//            compares them on the falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_cond_exec_pipe_ctrl;

  localparam int RA_W = 4;

  typedef struct packed {
    logic            valid;
    logic [3:0]      cond;
    logic            regw;
    logic            memw;
    logic            mtr;
    logic            br;
    logic            fw;
    logic [RA_W-1:0] ra1;
    logic [RA_W-1:0] ra2;
    logic [RA_W-1:0] wa3;
  } instr_t;

  typedef struct packed {
    logic       regw;
    logic       memw;
    logic       mtr;
    logic       pcsrc;
    logic       stall;
    logic       flush;
    logic [3:0] flags;
  } exp_t;

  typedef struct packed {
    exp_t e0;
    exp_t e1;
  } pair_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_d;
  logic [3:0]      cond_d;
  logic            regw_d, memw_d, mtr_d, br_d, fw_d;
  logic [RA_W-1:0] ra1_d, ra2_d, wa3_d;
  logic [3:0]      alu_e;

  logic            regw0, memw0, mtr0, pcsrc0, stall0, flush0;
  logic [3:0]      flags0;
  logic            regw1, memw1, mtr1, pcsrc1, stall1, flush1;
  logic [3:0]      flags1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  pair_t sbq[$];

  // Reference model state: the instruction sitting in E, the flags and the
  // number of flush cycles still owed, one set per instance.
  instr_t m_e[2];
  logic [3:0] m_flags[2];
  int m_left[2];

  always #5 clk = ~clk;

  cond_exec_pipe_ctrl #(.FLUSH_CYCLES(2), .RA_W(RA_W)) u_dut2 (
    .CLK(clk), .RST(rst), .Valid_D(valid_d), .Cond_D(cond_d),
    .RegW_D(regw_d), .MemW_D(memw_d), .MemToReg_D(mtr_d), .Branch_D(br_d),
    .FlagW_D(fw_d), .RA1_D(ra1_d), .RA2_D(ra2_d), .WA3_D(wa3_d),
    .ALUFlags_E(alu_e), .RegW_E(regw0), .MemW_E(memw0), .MemToReg_E(mtr0),
    .PCSrc_E(pcsrc0), .StallD(stall0), .FlushD(flush0), .Flags(flags0)
  );

  cond_exec_pipe_ctrl #(.FLUSH_CYCLES(3), .RA_W(RA_W)) u_dut3 (
    .CLK(clk), .RST(rst), .Valid_D(valid_d), .Cond_D(cond_d),
    .RegW_D(regw_d), .MemW_D(memw_d), .MemToReg_D(mtr_d), .Branch_D(br_d),
    .FlagW_D(fw_d), .RA1_D(ra1_d), .RA2_D(ra2_d), .WA3_D(wa3_d),
    .ALUFlags_E(alu_e), .RegW_E(regw1), .MemW_E(memw1), .MemToReg_E(mtr1),
    .PCSrc_E(pcsrc1), .StallD(stall1), .FlushD(flush1), .Flags(flags1)
  );

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int flush_len(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  // Predict this cycle's outputs for instance k and advance its model state.
  function automatic exp_t model_step(input int k, input logic rst_v,
                                      input instr_t d, input logic [3:0] alu);
    exp_t   x;
    instr_t e;
    logic   pass, hz;
    e    = m_e[k];
    pass = e.valid && cond_pass(e.cond, m_flags[k]);
    x.regw  = e.regw && pass;
    x.memw  = e.memw && pass;
    x.mtr   = e.mtr;
    x.pcsrc = e.br && pass;
    x.flush = x.pcsrc || (m_left[k] > 0);
    hz      = pass && e.mtr && e.regw && d.valid && (e.wa3 == d.ra1 || e.wa3 == d.ra2);
    x.stall = hz && !x.flush;
    x.flags = m_flags[k];
    if (!rst_v) begin
      m_e[k]     = '0;
      m_flags[k] = 4'h0;
      m_left[k]  = 0;
    end else begin
      if (e.fw && pass) m_flags[k] = alu;
      if (x.pcsrc) m_left[k] = flush_len(k) - 1;
      else if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
      m_e[k] = (d.valid && !x.stall && !x.flush) ? d : instr_t'(0);
    end
    return x;
  endfunction

  task automatic apply(input logic rst_v, input instr_t d, input logic [3:0] alu);
    pair_t p;
    rst = rst_v;
    valid_d = d.valid; cond_d = d.cond; regw_d = d.regw; memw_d = d.memw;
    mtr_d = d.mtr; br_d = d.br; fw_d = d.fw;
    ra1_d = d.ra1; ra2_d = d.ra2; wa3_d = d.wa3;
    alu_e = alu;
    p.e0 = model_step(0, rst_v, d, alu);
    p.e1 = model_step(1, rst_v, d, alu);
    sbq.push_back(p);
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t mk(input logic [3:0] c, input logic rw, input logic mw,
                                input logic mr, input logic b, input logic f,
                                input int a1, input int a2, input int w3);
    instr_t i;
    i.valid = 1'b1; i.cond = c; i.regw = rw; i.memw = mw; i.mtr = mr;
    i.br = b; i.fw = f;
    i.ra1 = RA_W'(a1); i.ra2 = RA_W'(a2); i.wa3 = RA_W'(w3);
    return i;
  endfunction

  task automatic chk(input string nm, input int k, input logic [3:0] act,
                     input logic [3:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, k, cyc, act, want);
    end
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest prediction.
  always @(negedge clk) begin
    pair_t p;
    exp_t  a[2];
    exp_t  w[2];
    if (sbq.size() != 0) begin
      p = sbq.pop_front();
      w[0] = p.e0;
      w[1] = p.e1;
      a[0] = '{regw0, memw0, mtr0, pcsrc0, stall0, flush0, flags0};
      a[1] = '{regw1, memw1, mtr1, pcsrc1, stall1, flush1, flags1};
      for (int k = 0; k < 2; k++) begin
        chk("RegW_E",     k, {3'b0, a[k].regw},  {3'b0, w[k].regw});
        chk("MemW_E",     k, {3'b0, a[k].memw},  {3'b0, w[k].memw});
        chk("MemToReg_E", k, {3'b0, a[k].mtr},   {3'b0, w[k].mtr});
        chk("PCSrc_E",    k, {3'b0, a[k].pcsrc}, {3'b0, w[k].pcsrc});
        chk("StallD",     k, {3'b0, a[k].stall}, {3'b0, w[k].stall});
        chk("FlushD",     k, {3'b0, a[k].flush}, {3'b0, w[k].flush});
        chk("Flags",      k, a[k].flags,         w[k].flags);
      end
      cyc++;
    end
  end

  initial begin
    instr_t nop, d;
    logic   r;
    nop = '0;
    for (int k = 0; k < 2; k++) begin
      m_e[k] = '0; m_flags[k] = 4'h0; m_left[k] = 0;
    end
    // First edge establishes a known state; nothing is predicted before it.
    rst = 1'b0; valid_d = 1'b1; regw_d = 1'b1; cond_d = 4'hE;
    memw_d = 1'b0; mtr_d = 1'b0; br_d = 1'b0; fw_d = 1'b0;
    ra1_d = '0; ra2_d = '0; wa3_d = '0; alu_e = 4'h0;
    @(posedge clk);
    #1;

    // Reset held with a live register-writing instruction in D
    apply(1'b0, mk(4'hE, 1, 0, 0, 0, 0, 0, 0, 1), 4'h0);
    apply(1'b0, mk(4'hE, 1, 0, 0, 0, 0, 0, 0, 1), 4'h0);
    // ADDS sets Z, then EQ passes, NE fails
    apply(1'b1, mk(4'hE, 1, 0, 0, 0, 1, 1, 2, 4), 4'h4);
    apply(1'b1, mk(4'h0, 1, 0, 0, 0, 0, 1, 2, 5), 4'h4);
    apply(1'b1, mk(4'h1, 1, 1, 0, 0, 0, 1, 2, 6), 4'h0);
    apply(1'b1, nop, 4'h0);
    // Load to r3, then consumer of r3: one stall cycle then issue
    apply(1'b1, mk(4'hE, 1, 0, 1, 0, 0, 0, 0, 3), 4'h0);
    apply(1'b1, mk(4'hE, 1, 0, 0, 0, 0, 3, 7, 8), 4'h0);
    apply(1'b1, mk(4'hE, 1, 0, 0, 0, 0, 3, 7, 8), 4'h0);
    apply(1'b1, nop, 4'h0);
    // Load to r3 followed by a branch, then hazard-pattern D during the flush
    apply(1'b1, mk(4'hE, 0, 0, 0, 1, 0, 0, 0, 0), 4'h0);
    for (int i = 0; i < 4; i++) apply(1'b1, mk(4'hE, 1, 0, 0, 0, 0, 0, 0, 9), 4'h0);
    apply(1'b1, mk(4'hE, 1, 0, 1, 0, 0, 0, 0, 3), 4'h0);
    apply(1'b1, mk(4'hE, 0, 0, 0, 1, 0, 3, 3, 0), 4'h0);
    apply(1'b1, mk(4'hE, 1, 0, 1, 0, 0, 3, 3, 3), 4'h0);
    apply(1'b1, mk(4'hE, 1, 0, 0, 0, 0, 3, 3, 3), 4'h0);
    apply(1'b1, mk(4'hE, 1, 0, 0, 0, 0, 3, 3, 3), 4'h0);
    // Never condition with S bit, then reset during a flush
    apply(1'b1, mk(4'hF, 1, 0, 0, 0, 1, 0, 0, 1), 4'hF);
    apply(1'b1, mk(4'hE, 0, 0, 0, 1, 0, 0, 0, 0), 4'hF);
    apply(1'b1, nop, 4'h0);
    apply(1'b0, nop, 4'h0);
    apply(1'b1, nop, 4'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r       = ($urandom_range(0, 59) != 0);
      d.valid = ($urandom_range(0, 7) != 0);
      d.cond  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      d.regw  = 1'($urandom_range(0, 1));
      d.memw  = ($urandom_range(0, 4) == 0);
      d.mtr   = ($urandom_range(0, 2) == 0);
      d.br    = ($urandom_range(0, 6) == 0);
      d.fw    = ($urandom_range(0, 2) == 0);
      d.ra1   = RA_W'($urandom_range(0, 3));
      d.ra2   = RA_W'($urandom_range(0, 3));
      d.wa3   = RA_W'($urandom_range(0, 3));
      apply(r, d, 4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
